// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: buffered UART transmitter; FIFO-fed, LSB-first frames (start, data, [parity], 1/2 stop).
// Latency: word accepted at edge N into an empty FIFO while idle -> popped at edge N+1 -> tx low from edge N+2.
// Backpressure: in_ready = !full (derived from the registered level); the host holds in_valid until accepted.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit (parity_odd: 0=even, 1=odd).
// Ports: clk/rst (sync, active-high); in_valid/in_data/in_ready host stream; baud_div (clk cycles per
//   bit, 0 treated as 1), stop2, parity_odd frame config (latched per frame); tx serial line (idle high);
//   busy frame in progress; done_tx pulse on the last cycle of the final stop bit; fifo_level words held.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic                        stop2,
  input  logic                        parity_odd,
  output logic                        tx,
  output logic                        busy,
  output logic                        done_tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_bit;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  // parity_odd has no function without the parity bit; the port stays for a fixed interface.
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // ---------------- FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;

  assign in_ready = (fifo_level != FULL_LVL);
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- Framer ----------------
  state_t                state;
  logic [DIV_WIDTH-1:0]  eff_div, timer;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  stop2_l, stop_phase;
  logic                  bit_end, stop_last;

  assign bit_end   = (timer == eff_div - 1'b1);
  // With two stop bits the STOP state runs two bit periods; stop_phase marks the second.
  assign stop_last = bit_end && (!stop2_l || stop_phase);
  // Pop from IDLE, or on the final stop cycle so the next start bit follows with no gap.
  assign pop = (fifo_level != '0) && ((state == IDLE) || ((state == STOP) && stop_last));

  // Outputs are registered from the current state, so tx/busy/done_tx all trail the
  // state register by one cycle and stay aligned with each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      eff_div    <= DIV_WIDTH'(1);
      stop2_l    <= 1'b0;
      stop_phase <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
      tx         <= 1'b1;
      busy       <= 1'b0;
      done_tx    <= 1'b0;
    end else begin
      busy    <= (state != IDLE);
      done_tx <= (state == STOP) && stop_last;
      timer   <= (state == IDLE || bit_end) ? '0 : timer + 1'b1;

      case (state)
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= par_bit;
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (stop_last) begin
              stop_phase <= 1'b0;
              state      <= IDLE;
            end else begin
              stop_phase <= 1'b1;
            end
          end
        end
        default: tx <= 1'b1;
      endcase

      // Loading a new word overrides the STOP->IDLE move above.
      if (pop) begin
        shift   <= mem[rd_ptr];
        eff_div <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
        stop2_l <= stop2;
`ifdef UART_TX_PARITY_EN
        par_bit <= (^mem[rd_ptr]) ^ parity_odd;
`endif
        timer   <= '0;
        state   <= START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
  localparam int DW   = 8;
  localparam int FD   = 4;
  localparam int DIVW = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [DIVW-1:0] baud_div;
  logic            stop2;
  logic            parity_odd;
  logic            tx, busy, done_tx;
  logic [2:0]      fifo_level;

  int errors = 0;
  int checks = 0;
  int last_gap = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .baud_div(baud_div), .stop2(stop2), .parity_odd(parity_odd), .tx(tx), .busy(busy),
    .done_tx(done_tx), .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input logic [DW-1:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("push_timeout", t < 3000, 1);
    exp_q.push_back(w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop bits; each bit eff cycles.
  task automatic check_frame(input int eff, input bit s2, input bit po);
    bit            bits[32];
    int            nb, len, t, bad_tx, bad_done, bad_busy;
    logic [DW-1:0] w, got;
    t = 0;
    while (tx !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    last_gap = t;
    check("frame_start_timeout", t < 3000, 1);
    if (t >= 3000) return;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", exp_q.size(), 1);
      return;
    end
    w  = exp_q.pop_front();
    nb = 0;
    bits[nb] = 1'b0; nb = nb + 1;
    for (int i = 0; i < DW; i++) begin
      bits[nb] = w[i]; nb = nb + 1;
    end
    if (PB != 0) begin
      bits[nb] = (^w) ^ po; nb = nb + 1;
    end
    bits[nb] = 1'b1; nb = nb + 1;
    if (s2) begin
      bits[nb] = 1'b1; nb = nb + 1;
    end
    len = nb * eff;
    got = '0; bad_tx = 0; bad_done = 0; bad_busy = 0;
    for (int k = 0; k < len; k++) begin
      if (tx !== bits[k / eff]) bad_tx++;
      if (done_tx !== (k == len - 1)) bad_done++;
      if (busy !== 1'b1) bad_busy++;
      if (k >= eff && k < (1 + DW) * eff && (k % eff) == eff / 2) got[k / eff - 1] = tx;
      @(negedge clk);
    end
    check("frame_tx_cycles_bad", bad_tx, 0);
    check("frame_done_cycles_bad", bad_done, 0);
    check("frame_busy_cycles_bad", bad_busy, 0);
    check("frame_data", got, w);
  endtask

  initial begin
    int t, bad, n_done, n_low, eff;
    bit s2, po;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    baud_div = 16'd4; stop2 = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx, busy, done_tx, in_ready, fifo_level}, {1'b1, 1'b0, 1'b0, 1'b1, 3'd0});
    rst = 1'b0;

    // Idle for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if ({tx, busy, in_ready, fifo_level} !== {1'b1, 1'b0, 1'b1, 3'd0}) bad++;
      @(negedge clk);
    end
    check("idle_100_bad_cycles", bad, 0);

    // 0xA5 at baud 4, one stop bit; first-word latency
    baud_div = 16'd4; stop2 = 1'b0;
    push(8'hA5);
    check_frame(4, 1'b0, 1'b0);
    check("a5_first_tx_low_gap", last_gap, 2);
    check("a5_busy_after_frame", {busy, tx, done_tx}, {1'b0, 1'b1, 1'b0});

    // Six words back to back: backpressure after the 5th accept, contiguous frames
    baud_div = 16'd2;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(8'(8'h30 + i * 7));
          if (i == 4) begin
            check("burst_in_ready_full", in_ready, 0);
            check("burst_level_full", fifo_level, 4);
          end
        end
      end
      begin
        for (int j = 0; j < 6; j++) begin
          check_frame(2, 1'b0, 1'b0);
          if (j > 0) check("burst_gap", last_gap, 0);
        end
      end
    join
    check("burst_idle_after", {busy, fifo_level}, {1'b0, 3'd0});

    // baud_div 0 acts as 1: 10-cycle frame, then 11 with two stop bits
    baud_div = 16'd0; stop2 = 1'b0;
    push(8'h00);
    check_frame(1, 1'b0, 1'b0);
    stop2 = 1'b1;
    push(8'h00);
    check_frame(1, 1'b1, 1'b0);

    // Parity cases (frames still checked without the parity bit in the default build)
    baud_div = 16'd2; stop2 = 1'b0; parity_odd = 1'b0;
    push(8'h07);
    check_frame(2, 1'b0, 1'b0);
    parity_odd = 1'b1;
    push(8'h03);
    check_frame(2, 1'b0, 1'b1);

    // Config changes mid-frame must not affect the frame in flight
    baud_div = 16'd3; stop2 = 1'b0; parity_odd = 1'b0;
    push(8'h5C);
    fork
      check_frame(3, 1'b0, 1'b0);
      begin
        repeat (6) @(negedge clk);
        baud_div = 16'd1; stop2 = 1'b1; parity_odd = 1'b1;
      end
    join

    // Randomized batches with random config and gaps
    for (int b = 0; b < 6; b++) begin
      baud_div   = 16'($urandom_range(0, 5));
      stop2      = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      eff = (baud_div == 0) ? 1 : int'(baud_div);
      s2 = stop2; po = parity_odd;
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 25)) @(negedge clk);
          end
        end
        begin
          for (int j = 0; j < 5; j++) check_frame(eff, s2, po);
        end
      join
    end
    check("queue_drained", exp_q.size(), 0);

    // Reset mid-DATA with two words queued
    baud_div = 16'd4; stop2 = 1'b0; parity_odd = 1'b0;
    push(8'hF0); push(8'h11); push(8'h22);
    t = 0;
    while (tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_frame_start_timeout", t < 100, 1);
    repeat (8) @(negedge clk);
    check("rst_pre_level", fifo_level, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {tx, busy, done_tx, fifo_level, in_ready}, {1'b1, 1'b0, 1'b0, 3'd0, 1'b1});
    rst = 1'b0;
    exp_q.delete();
    n_done = 0; n_low = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_tx !== 1'b0) n_done++;
      if (tx !== 1'b1) n_low++;
      @(negedge clk);
    end
    check("rst_no_done_pulse", n_done, 0);
    check("rst_tx_stays_high", n_low, 0);
    check("rst_stays_idle", {busy, fifo_level}, {1'b0, 3'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
